// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of an async FIFO (rclk domain).
// Optional almost_empty flag: define FIFO_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
   parameter int PTR_WIDTH       = 3,
   parameter int ALMOST_EMPTY_TH = 1
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 r_en,
   input  logic [PTR_WIDTH:0]   g_wptr,
   output logic [PTR_WIDTH:0]   b_rptr,
   output logic [PTR_WIDTH:0]   g_rptr,
   output logic                 empty,
   output logic [PTR_WIDTH:0]   rd_count,
   output logic                 underflow
`ifdef FIFO_ALMOST_EMPTY_EN
   ,output logic                almost_empty
`endif
);

   localparam int AW = PTR_WIDTH + 1;

   logic [AW-1:0] wq1;
   logic [AW-1:0] wq2;
   logic          rd_fire;
   logic [AW-1:0] b_rnext;
   logic [AW-1:0] g_rnext;
   logic [AW-1:0] w_bin;
   logic [AW-1:0] count_next;

   function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
      logic [AW-1:0] b;
      b[AW-1] = g[AW-1];
      for (int i = AW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Plain two-flop synchroniser; nothing may sit between the stages.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         wq1 <= '0;
         wq2 <= '0;
      end else begin
         wq1 <= g_wptr;
         wq2 <= wq1;
      end
   end

   always_comb begin
      rd_fire    = r_en & ~empty;
      b_rnext    = b_rptr + AW'(rd_fire);
      g_rnext    = (b_rnext >> 1) ^ b_rnext;
      w_bin      = gray2bin(wq2);
      count_next = w_bin - b_rnext;
   end

   // wq2 lags the real write pointer, so empty and rd_count are pessimistic.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         b_rptr    <= '0;
         g_rptr    <= '0;
         empty     <= 1'b1;
         rd_count  <= '0;
         underflow <= 1'b0;
      end else begin
         b_rptr    <= b_rnext;
         g_rptr    <= g_rnext;
         empty     <= (g_rnext == wq2);
         rd_count  <= count_next;
         underflow <= r_en & empty;
      end
   end

`ifdef FIFO_ALMOST_EMPTY_EN
   localparam logic [AW-1:0] AE_TH = AW'(ALMOST_EMPTY_TH);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         almost_empty <= 1'b1;
      end else begin
         almost_empty <= (count_next <= AE_TH);
      end
   end
`else
   // Without the almost_empty flag, count_next only feeds rd_count.
`endif

endmodule
